// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues sequential requests to a synchronous
// instruction memory, presents fetched instructions through IF/ID registers, and handles
// execute-stage redirects. A one-entry skid buffer catches the in-flight response when
// decode stalls.
module fetch_stage #(
    parameter int unsigned          PC_WIDTH = 32,
    parameter int unsigned          IWIDTH   = 32,
    parameter logic [PC_WIDTH-1:0]  RESET_PC = '0
) (
    input  logic                fs_i_clk,
    input  logic                fs_i_rst,
    input  logic                fs_i_stall,
    input  logic                fs_i_change_pc,
    input  logic [PC_WIDTH-1:0] fs_i_alu_pc,
    output logic                fs_o_imem_req,
    output logic [PC_WIDTH-1:0] fs_o_imem_addr,
    input  logic [IWIDTH-1:0]   fs_i_imem_instr,
    output logic [IWIDTH-1:0]   fs_o_instr,
    output logic [PC_WIDTH-1:0] fs_o_pc,
    output logic                fs_o_ce,
    output logic                fs_o_flush,
    output logic                fs_o_misalign
);

    typedef enum logic [1:0] {
        StBoot,
        StRun,
        StHold
    } state_e;

    state_e                state_q, state_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic                  inflight_q, inflight_d;
    logic [PC_WIDTH-1:0]   inflight_pc_q, inflight_pc_d;
    logic                  skid_v_q, skid_v_d;
    logic [IWIDTH-1:0]     skid_instr_q, skid_instr_d;
    logic [PC_WIDTH-1:0]   skid_pc_q, skid_pc_d;
    logic [IWIDTH-1:0]     instr_q, instr_d;
    logic [PC_WIDTH-1:0]   out_pc_q, out_pc_d;
    logic                  ce_q, ce_d;
    logic                  misalign_q, misalign_d;
    logic                  req;

    assign req            = (state_q != StBoot) && !fs_i_stall && !fs_i_change_pc;
    assign fs_o_imem_req  = req;
    assign fs_o_imem_addr = pc_q;
    assign fs_o_instr     = instr_q;
    assign fs_o_pc        = out_pc_q;
    assign fs_o_ce        = ce_q;
    assign fs_o_flush     = fs_i_change_pc;
    assign fs_o_misalign  = misalign_q;

    // Next-state logic: redirect first, then the BOOT/RUN/HOLD sequencing.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        inflight_d    = req;
        inflight_pc_d = pc_q;
        skid_v_d      = skid_v_q;
        skid_instr_d  = skid_instr_q;
        skid_pc_d     = skid_pc_q;
        instr_d       = instr_q;
        out_pc_d      = out_pc_q;
        ce_d          = ce_q;
        misalign_d    = 1'b0;

        if (req) begin
            pc_d = pc_q + PC_WIDTH'(4);
        end

        if (fs_i_change_pc) begin
            // The response arriving now is wrong-path; drop it and any skidded entry.
            pc_d       = {fs_i_alu_pc[PC_WIDTH-1:2], 2'b00};
            misalign_d = |fs_i_alu_pc[1:0];
            skid_v_d   = 1'b0;
            ce_d       = 1'b0;
            state_d    = (state_q == StBoot) ? StBoot : StRun;
        end else begin
            case (state_q)
                StBoot: begin
                    state_d = StRun;
                end
                StRun: begin
                    if (!fs_i_stall) begin
                        if (inflight_q) begin
                            instr_d  = fs_i_imem_instr;
                            out_pc_d = inflight_pc_q;
                            ce_d     = 1'b1;
                        end else begin
                            ce_d = 1'b0;
                        end
                    end else if (inflight_q) begin
                        // Decode is frozen but memory still answers: park the response.
                        skid_v_d     = 1'b1;
                        skid_instr_d = fs_i_imem_instr;
                        skid_pc_d    = inflight_pc_q;
                        state_d      = StHold;
                    end
                end
                StHold: begin
                    if (!fs_i_stall) begin
                        instr_d  = skid_instr_q;
                        out_pc_d = skid_pc_q;
                        ce_d     = skid_v_q;
                        skid_v_d = 1'b0;
                        state_d  = StRun;
                    end
                end
                default: begin
                    state_d = StBoot;
                end
            endcase
        end
    end

    // State and IF/ID registers.
    always_ff @(posedge fs_i_clk or posedge fs_i_rst) begin
        if (fs_i_rst) begin
            state_q       <= StBoot;
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            skid_v_q      <= 1'b0;
            skid_instr_q  <= '0;
            skid_pc_q     <= '0;
            instr_q       <= '0;
            out_pc_q      <= '0;
            ce_q          <= 1'b0;
            misalign_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            skid_v_q      <= skid_v_d;
            skid_instr_q  <= skid_instr_d;
            skid_pc_q     <= skid_pc_d;
            instr_q       <= instr_d;
            out_pc_q      <= out_pc_d;
            ce_q          <= ce_d;
            misalign_q    <= misalign_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: boot, stall with skid, redirect, redirect during
// hold, misaligned target, PC wrap and asynchronous reset mid-stream.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        change_pc = 1'b0;
    logic [31:0] alu_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr = '0;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        ce;
    logic        flush;
    logic        misalign;

    int passes = 0;
    int total  = 0;
    int cyc    = 0;

    fetch_stage #(
        .PC_WIDTH (32),
        .IWIDTH   (32),
        .RESET_PC (32'h0)
    ) dut (
        .fs_i_clk        (clk),
        .fs_i_rst        (rst),
        .fs_i_stall      (stall),
        .fs_i_change_pc  (change_pc),
        .fs_i_alu_pc     (alu_pc),
        .fs_o_imem_req   (imem_req),
        .fs_o_imem_addr  (imem_addr),
        .fs_i_imem_instr (imem_instr),
        .fs_o_instr      (instr),
        .fs_o_pc         (pc),
        .fs_o_ce         (ce),
        .fs_o_flush      (flush),
        .fs_o_misalign   (misalign)
    );

    always #5 clk = ~clk;

    // Synchronous memory: mem[i] = 0x1000_0000 + i; junk when no request was made.
    always @(posedge clk) begin
        imem_instr <= imem_req ? (32'h1000_0000 + (imem_addr >> 2)) : 32'hdead_beef;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s (cycle %0d): observed %h expected %h", tag, cyc, obs, exp);
    endtask

    // Release reset just after an edge; the following cycle is cycle 0 (BOOT).
    task automatic do_reset();
        stall     = 1'b0;
        change_pc = 1'b0;
        alu_pc    = '0;
        rst       = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    initial begin
        // ---- Boot and stall with skid ----
        do_reset();
        #1;
        chk("boot_ce", ce, 0);
        chk("boot_req", imem_req, 0);
        chk("boot_pc", pc, 0);
        chk("boot_instr", instr, 0);
        chk("boot_misalign", misalign, 0);
        run_to(1);
        chk("c1_req", imem_req, 1);
        chk("c1_addr", imem_addr, 32'h0);
        run_to(2);
        chk("c2_ce", ce, 0);
        run_to(3);
        chk("c3_ce", ce, 1);
        chk("c3_pc", pc, 32'h0);
        chk("c3_instr", instr, 32'h1000_0000);
        run_to(4);
        chk("c4_pc", pc, 32'h4);
        run_to(5);
        stall = 1'b1;
        #1;
        chk("stall_c5_pc", pc, 32'h8);
        chk("stall_c5_req", imem_req, 0);
        run_to(6);
        chk("stall_c6_pc", pc, 32'h8);
        chk("stall_c6_instr", instr, 32'h1000_0002);
        run_to(7);
        chk("stall_c7_pc", pc, 32'h8);
        chk("stall_c7_req", imem_req, 0);
        run_to(8);
        stall = 1'b0;
        #1;
        chk("release_req", imem_req, 1);
        chk("release_addr", imem_addr, 32'h10);
        chk("release_pc", pc, 32'h8);
        run_to(9);
        chk("skid_pc", pc, 32'hc);
        chk("skid_instr", instr, 32'h1000_0003);
        chk("skid_ce", ce, 1);
        run_to(10);
        chk("after_skid_pc", pc, 32'h10);
        chk("after_skid_instr", instr, 32'h1000_0004);

        // ---- Redirect to 0x40 in cycle 8 ----
        do_reset();
        run_to(8);
        chk("pre_redir_pc", pc, 32'h14);
        change_pc = 1'b1;
        alu_pc    = 32'h40;
        #1;
        chk("redir_flush", flush, 1);
        chk("redir_req", imem_req, 0);
        run_to(9);
        change_pc = 1'b0;
        #1;
        chk("redir_c9_flush", flush, 0);
        chk("redir_c9_ce", ce, 0);
        chk("redir_c9_addr", imem_addr, 32'h40);
        chk("redir_c9_req", imem_req, 1);
        run_to(10);
        chk("redir_c10_ce", ce, 0);
        run_to(11);
        chk("redir_c11_ce", ce, 1);
        chk("redir_c11_pc", pc, 32'h40);
        chk("redir_c11_instr", instr, 32'h1000_0010);
        run_to(12);
        chk("redir_c12_pc", pc, 32'h44);

        // ---- Redirect during HOLD ----
        do_reset();
        run_to(5);
        stall = 1'b1;
        run_to(7);
        change_pc = 1'b1;
        alu_pc    = 32'h80;
        #1;
        chk("hold_redir_req", imem_req, 0);
        run_to(8);
        change_pc = 1'b0;
        #1;
        chk("hold_redir_c8_ce", ce, 0);
        chk("hold_redir_c8_req", imem_req, 0);
        run_to(9);
        chk("hold_redir_c9_ce", ce, 0);
        run_to(10);
        stall = 1'b0;
        #1;
        chk("hold_redir_c10_addr", imem_addr, 32'h80);
        chk("hold_redir_c10_ce", ce, 0);
        run_to(11);
        chk("hold_redir_c11_ce", ce, 0);
        run_to(12);
        chk("hold_redir_c12_ce", ce, 1);
        chk("hold_redir_c12_pc", pc, 32'h80);

        // ---- Misaligned target, then wrap ----
        do_reset();
        run_to(4);
        change_pc = 1'b1;
        alu_pc    = 32'h43;
        run_to(5);
        change_pc = 1'b0;
        #1;
        chk("mis_pulse", misalign, 1);
        chk("mis_addr", imem_addr, 32'h40);
        run_to(6);
        chk("mis_pulse_end", misalign, 0);
        run_to(7);
        chk("mis_pc", pc, 32'h40);
        chk("mis_ce", ce, 1);
        run_to(8);
        change_pc = 1'b1;
        alu_pc    = 32'hffff_fffc;
        run_to(9);
        change_pc = 1'b0;
        #1;
        chk("wrap_misalign", misalign, 0);
        run_to(11);
        chk("wrap_pc_top", pc, 32'hffff_fffc);
        chk("wrap_instr_top", instr, 32'h4fff_ffff);
        run_to(12);
        chk("wrap_pc_zero", pc, 32'h0);
        chk("wrap_instr_zero", instr, 32'h1000_0000);

        // ---- Asynchronous reset mid-stream ----
        do_reset();
        run_to(5);
        chk("mid_pre_ce", ce, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_ce", ce, 0);
        chk("mid_rst_pc", pc, 0);
        chk("mid_rst_instr", instr, 0);
        chk("mid_rst_req", imem_req, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        #1;
        chk("reboot_c0_req", imem_req, 0);
        run_to(1);
        chk("reboot_c1_addr", imem_addr, 32'h0);
        run_to(2);
        chk("reboot_c2_ce", ce, 0);
        run_to(3);
        chk("reboot_c3_ce", ce, 1);
        chk("reboot_c3_pc", pc, 32'h0);
        chk("reboot_c3_instr", instr, 32'h1000_0000);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
